// File: rtl/key_calc_ctrl_pkg.sv
// Shared definitions for the key-driven calculator controller.
// Holds the controller state encoding, the key-code map and a small
// helper that classifies operand keys.
package key_calc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GOT_A,
      ST_GOT_B,
      ST_ADD_WAIT,
      ST_SHOW
   } state_t;

   localparam int KEY_OP_MIN = 1;
   localparam int KEY_OP_MAX = 12;
   localparam int KEY_SAME   = 13;
   localparam int KEY_CLR    = 14;
   localparam int KEY_BEEP   = 15;
   localparam int KEY_EQ     = 16;

   function automatic logic is_operand(input int code);
      return (code >= KEY_OP_MIN) && (code <= KEY_OP_MAX);
   endfunction

endpackage

// File: rtl/key_calc_ctrl_if.sv
// Bundle of all non-clock signals of the calculator controller.
//   key_valid/key_code/key_ready : debounced key handshake
//   op_a/op_b/add_req/add_ack/add_sum : external adder request/response
//   result/result_valid : registered sum for the LED display
//   buzzer/busy : beep output and adder-wait indication
// The master modport is the controller; the slave modport is its environment
// (keypad, adder, display).
interface key_calc_ctrl_if #(
   parameter int DATA_W = 5
);
   logic              key_valid;
   logic [DATA_W-1:0] key_code;
   logic              key_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              add_req;
   logic              add_ack;
   logic [DATA_W:0]   add_sum;
   logic [DATA_W:0]   result;
   logic              result_valid;
   logic              buzzer;
   logic              busy;

   modport master (
      input  key_valid, key_code, add_ack, add_sum,
      output key_ready, op_a, op_b, add_req, result, result_valid, buzzer, busy
   );

   modport slave (
      output key_valid, key_code, add_ack, add_sum,
      input  key_ready, op_a, op_b, add_req, result, result_valid, buzzer, busy
   );
endinterface

// File: rtl/key_calc_ctrl_beep_timer.sv
// beep_timer: one-shot buzzer pulse generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : (re)start the pulse; a load while running restarts the count
//   buzzer_o   : registered, high for BEEP_CYCLES cycles after the last load
module beep_timer #(
   parameter int BEEP_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   output logic buzzer_o
);
   localparam int CNT_W = $clog2(BEEP_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             buzzer_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_W'(BEEP_CYCLES);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Buzzer tracks the counter value after the edge, so it rises together
   // with the load and stays high for exactly BEEP_CYCLES cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         buzzer_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         buzzer_q <= (cnt_d != '0);
      end
   end

   assign buzzer_o = buzzer_q;
endmodule

// File: rtl/key_calc_ctrl.sv
// key_calc_ctrl: keypad-driven two-operand adder controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : key handshake, adder request/response, display and buzzer
// Operand keys fill op_a then op_b, equals issues an adder request and waits
// for the ack (bounded by ACK_TIMEOUT), the sum is held for display. Illegal
// actions and key 15 sound the buzzer via beep_timer.
module key_calc_ctrl
   import key_calc_ctrl_pkg::*;
#(
   parameter int DATA_W      = 5,
   parameter int BEEP_CYCLES = 100000,
   parameter int ACK_TIMEOUT = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   key_calc_ctrl_if.master       bus
);
   localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

   state_t            state_q;
   logic [DATA_W-1:0] op_a_q, op_b_q;
   logic [DATA_W:0]   result_q;
   logic              result_valid_q;
   logic              add_req_q;
   logic              same_en_q;
   logic [WAIT_W-1:0] wait_cnt_q;

   int   code;
   logic accept, is_op, reject_same, reject_eq, timeout, beep_load;

   assign code   = int'(bus.key_code);
   assign accept = bus.key_valid && (state_q != ST_ADD_WAIT);
   assign is_op  = is_operand(code);

   // Second operand equal to the first is refused unless same-enable is set.
   assign reject_same = is_op && (state_q == ST_GOT_A || state_q == ST_GOT_B)
                        && (bus.key_code == op_a_q) && !same_en_q;
   assign reject_eq   = (code == KEY_EQ) && (state_q != ST_GOT_B);
   assign timeout     = (state_q == ST_ADD_WAIT) && !bus.add_ack
                        && (wait_cnt_q == WAIT_W'(ACK_TIMEOUT - 1));
   assign beep_load   = (accept && (code == KEY_BEEP || reject_same || reject_eq))
                        || timeout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         op_a_q         <= '0;
         op_b_q         <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         add_req_q      <= 1'b0;
         same_en_q      <= 1'b0;
         wait_cnt_q     <= '0;
      end else if (state_q == ST_ADD_WAIT) begin
         // Ack wins over a timeout landing on the same cycle.
         if (bus.add_ack) begin
            result_q       <= bus.add_sum;
            result_valid_q <= 1'b1;
            add_req_q      <= 1'b0;
            wait_cnt_q     <= '0;
            state_q        <= ST_SHOW;
         end else if (timeout) begin
            result_valid_q <= 1'b0;
            add_req_q      <= 1'b0;
            wait_cnt_q     <= '0;
            state_q        <= ST_IDLE;
         end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
         end
      end else if (accept) begin
         if (code == KEY_CLR) begin
            op_a_q         <= '0;
            op_b_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            same_en_q      <= 1'b0;
            state_q        <= ST_IDLE;
         end else if (code == KEY_SAME) begin
            same_en_q <= 1'b1;
         end else if (is_op && !reject_same) begin
            if (state_q == ST_IDLE || state_q == ST_SHOW) begin
               op_a_q  <= bus.key_code;
               state_q <= ST_GOT_A;
            end else begin
               op_b_q  <= bus.key_code;
               state_q <= ST_GOT_B;
            end
         end else if (code == KEY_EQ && state_q == ST_GOT_B) begin
            add_req_q  <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= ST_ADD_WAIT;
         end
      end
   end

   beep_timer #(
      .BEEP_CYCLES (BEEP_CYCLES)
   ) u_beep (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (beep_load),
      .buzzer_o (bus.buzzer)
   );

   assign bus.key_ready    = (state_q != ST_ADD_WAIT);
   assign bus.busy         = (state_q == ST_ADD_WAIT);
   assign bus.op_a         = op_a_q;
   assign bus.op_b         = op_b_q;
   assign bus.add_req      = add_req_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
endmodule

// File: tb/tb_key_calc_ctrl.sv
// Directed testbench for key_calc_ctrl with shortened beep and ack timeouts.
module tb_key_calc_ctrl;
   import key_calc_ctrl_pkg::*;

   localparam int DW   = 5;
   localparam int BEEP = 20;
   localparam int TO   = 12;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   n;

   always #5 clk = ~clk;

   key_calc_ctrl_if #(.DATA_W(DW)) bus ();

   key_calc_ctrl #(
      .DATA_W      (DW),
      .BEEP_CYCLES (BEEP),
      .ACK_TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Key held across exactly one rising edge; returns on the following
   // falling edge, where the registered response is visible.
   task automatic press(input int code);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = DW'(code);
      @(negedge clk);
      bus.key_valid = 1'b0;
   endtask

   task automatic ack_after(input int dly, input int sum);
      repeat (dly - 1) @(negedge clk);
      bus.add_ack = 1'b1;
      bus.add_sum = (DW + 1)'(sum);
      @(negedge clk);
      bus.add_ack = 1'b0;
   endtask

   task automatic buzz_len(output int cnt);
      cnt = 0;
      while (bus.buzzer && cnt < 1000) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.key_valid = 1'b0;
      bus.key_code  = '0;
      bus.add_ack   = 1'b0;
      bus.add_sum   = '0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_add_req", bus.add_req, 0);
      check("rst_buzzer", bus.buzzer, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_state", int'(dut.state_q), int'(ST_IDLE));
      check("rst_op_a", bus.op_a, 0);
      check("rst_result", bus.result, 0);
      check("rst_rvalid", bus.result_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_key_ready", bus.key_ready, 1);

      // 3 + 7 = 10, ack after 5 cycles
      press(3);
      check("a_state", int'(dut.state_q), int'(ST_GOT_A));
      check("a_op_a", bus.op_a, 3);
      press(7);
      check("b_state", int'(dut.state_q), int'(ST_GOT_B));
      check("b_op_b", bus.op_b, 7);
      press(16);
      check("eq_add_req", bus.add_req, 1);
      check("eq_busy", bus.busy, 1);
      check("eq_key_ready", bus.key_ready, 0);
      ack_after(5, 10);
      check("ack_state", int'(dut.state_q), int'(ST_SHOW));
      check("ack_result", bus.result, 10);
      check("ack_rvalid", bus.result_valid, 1);
      check("ack_add_req", bus.add_req, 0);
      check("ack_buzzer", bus.buzzer, 0);
      // stray ack in SHOW must not touch the result
      ack_after(1, 31);
      check("stray_ack_result", bus.result, 10);

      // clear, then 4,4 without same-enable
      press(14);
      check("clr_state", int'(dut.state_q), int'(ST_IDLE));
      check("clr_result", bus.result, 0);
      check("clr_rvalid", bus.result_valid, 0);
      check("clr_buzzer", bus.buzzer, 0);
      press(4);
      press(4);
      check("same_rej_state", int'(dut.state_q), int'(ST_GOT_A));
      check("same_rej_op_b", bus.op_b, 0);
      buzz_len(n);
      check("same_rej_beep_len", n, BEEP);
      press(13);
      check("same_en_state", int'(dut.state_q), int'(ST_GOT_A));
      check("same_en_buzzer", bus.buzzer, 0);
      press(4);
      check("same_ok_state", int'(dut.state_q), int'(ST_GOT_B));
      press(16);
      check("same_add_req", bus.add_req, 1);
      check("same_op_a", bus.op_a, 4);
      check("same_op_b", bus.op_b, 4);
      ack_after(2, 8);
      check("same_result", bus.result, 8);

      // equals in SHOW is rejected with a beep
      press(16);
      check("show_eq_state", int'(dut.state_q), int'(ST_SHOW));
      buzz_len(n);
      check("show_eq_beep_len", n, BEEP);
      press(2);
      check("show_op_state", int'(dut.state_q), int'(ST_GOT_A));
      check("show_op_a", bus.op_a, 2);
      check("show_op_rvalid", bus.result_valid, 1);

      // invalid code ignored silently; equals in GOT_A beeps
      press(20);
      check("inv_state", int'(dut.state_q), int'(ST_GOT_A));
      check("inv_buzzer", bus.buzzer, 0);
      check("inv_op_a", bus.op_a, 2);
      press(0);
      check("zero_state", int'(dut.state_q), int'(ST_GOT_A));
      press(16);
      check("gota_eq_state", int'(dut.state_q), int'(ST_GOT_A));
      buzz_len(n);
      check("gota_eq_beep_len", n, BEEP);

      // 2, 9, = with no ack -> timeout
      press(9);
      press(16);
      n = 0;
      while (bus.add_req && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("to_req_len", n, TO);
      check("to_state", int'(dut.state_q), int'(ST_IDLE));
      check("to_rvalid", bus.result_valid, 0);
      check("to_buzzer", bus.buzzer, 1);
      buzz_len(n);

      // clear held during ADD_WAIT
      press(14);
      press(3);
      press(7);
      press(16);
      @(negedge clk);
      bus.key_valid = 1'b1;
      bus.key_code  = DW'(14);
      repeat (3) @(negedge clk);
      check("hold_state", int'(dut.state_q), int'(ST_ADD_WAIT));
      check("hold_key_ready", bus.key_ready, 0);
      bus.add_ack = 1'b1;
      bus.add_sum = (DW + 1)'(10);
      @(negedge clk);
      bus.add_ack = 1'b0;
      check("hold_show_state", int'(dut.state_q), int'(ST_SHOW));
      check("hold_show_result", bus.result, 10);
      @(negedge clk);
      bus.key_valid = 1'b0;
      check("hold_clr_state", int'(dut.state_q), int'(ST_IDLE));
      check("hold_clr_result", bus.result, 0);

      // asynchronous reset in ADD_WAIT
      press(3);
      press(7);
      press(15);
      press(16);
      check("pre_rst_add_req", bus.add_req, 1);
      #2 rst_n = 1'b0;
      #1 check("async_add_req", bus.add_req, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_state", int'(dut.state_q), int'(ST_IDLE));
      check("post_rst_op_a", bus.op_a, 0);
      check("post_rst_op_b", bus.op_b, 0);
      check("post_rst_buzzer", bus.buzzer, 0);
      check("post_rst_busy", bus.busy, 0);
      check("post_rst_key_ready", bus.key_ready, 1);

      // beep retrigger 10 cycles apart
      press(15);
      n = 0;
      for (int i = 0; i < 200; i++) begin
         if (!bus.buzzer) break;
         n++;
         if (i == 9) begin
            bus.key_valid = 1'b1;
            bus.key_code  = DW'(15);
         end else if (i == 10) begin
            bus.key_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("retrig_beep_len", n, 10 + BEEP);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
